// File: rtl/zeroriscy_sys_arbiter.sv
// Arbitrates the instruction and data masters onto the single system slave port,
// keeping at most one transaction outstanding. Optional response timeout: SYS_ARB_TIMEOUT_EN.
module zeroriscy_sys_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TO_W       = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic        im_gnt,
    output logic        im_rvalid,
    output logic [31:0] im_rdata,
    output logic        im_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        ss_req,
    output logic        ss_we,
    output logic [3:0]  ss_be,
    output logic [31:0] ss_addr,
    output logic [31:0] ss_wdata,
    input  logic        ss_gnt,
    input  logic        ss_rvalid,
    input  logic [31:0] ss_rdata,
    input  logic        ss_err,
    output logic        busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    localparam logic       SEL_DM     = 1'b0;
    localparam logic       SEL_IM     = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e      state_r, state_n_s;
    logic        owner_r, lock_r, lock_win_r;
    logic [3:0]  starve_cnt_r;
    logic        winner_s, accept_s, resp_s, timeout_s;
    logic        resp_err_s;
    logic [31:0] resp_data_s;

`ifdef SYS_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 32'd1);
    logic [TO_W-1:0] to_cnt_r;

    // Fires in the TIMEOUT-th BUSY cycle when the slave has still not answered.
    assign timeout_s = (state_r == ST_BUSY) && (to_cnt_r == TO_LAST) && !ss_rvalid;

    // Busy-cycle counter, restarted on every accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (accept_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_BUSY) begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_to_cfg_s;
    assign unused_to_cfg_s = (TIMEOUT >= (32'd1 << TO_W));
    assign timeout_s       = 1'b0;
`endif

    // Winner selection and request/response decode.
    always_comb begin
        winner_s    = SEL_DM;
        ss_req      = 1'b0;
        resp_s      = 1'b0;
        resp_err_s  = 1'b1;
        resp_data_s = 32'h0;
        if (lock_r) begin
            winner_s = lock_win_r;
        end else if (im_req && (!dm_req || starve_cnt_r == STARVE_LIM)) begin
            winner_s = SEL_IM;
        end else begin
            winner_s = SEL_DM;
        end
        if (resetn && state_r == ST_IDLE) begin
            ss_req = im_req | dm_req;
        end else if (resetn) begin
            resp_s = ss_rvalid | timeout_s;
        end else begin
            ss_req = 1'b0;
        end
        if (ss_rvalid) begin
            resp_err_s  = ss_err;
            resp_data_s = ss_rdata;
        end else begin
            resp_err_s  = 1'b1;
            resp_data_s = 32'h0;
        end
    end

    assign accept_s  = ss_req & ss_gnt;
    assign state_n_s = accept_s ? ST_BUSY : (resp_s ? ST_IDLE : state_r);

    assign ss_we    = (winner_s == SEL_DM) ? dm_we    : 1'b0;
    assign ss_be    = (winner_s == SEL_DM) ? dm_be    : 4'hf;
    assign ss_addr  = (winner_s == SEL_DM) ? dm_addr  : im_addr;
    assign ss_wdata = (winner_s == SEL_DM) ? dm_wdata : 32'h0;

    assign im_gnt    = accept_s & (winner_s == SEL_IM);
    assign dm_gnt    = accept_s & (winner_s == SEL_DM);
    assign im_rvalid = resp_s & (owner_r == SEL_IM);
    assign dm_rvalid = resp_s & (owner_r == SEL_DM);
    assign im_rdata  = im_rvalid ? resp_data_s : 32'h0;
    assign dm_rdata  = dm_rvalid ? resp_data_s : 32'h0;
    assign im_err    = im_rvalid & resp_err_s;
    assign dm_err    = dm_rvalid & resp_err_s;
    assign busy      = resetn & (state_r == ST_BUSY);

    // State, ownership, lock and starvation bookkeeping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            owner_r      <= SEL_DM;
            lock_r       <= 1'b0;
            lock_win_r   <= SEL_DM;
            starve_cnt_r <= 4'd0;
        end else begin
            state_r <= state_n_s;
            if (accept_s) begin
                owner_r <= winner_s;
                lock_r  <= 1'b0;
                if (winner_s == SEL_IM) begin
                    starve_cnt_r <= 4'd0;
                end else if (im_req && starve_cnt_r != STARVE_LIM) begin
                    starve_cnt_r <= starve_cnt_r + 4'd1;
                end
            end else if (ss_req) begin
                // A stalled request keeps its winner until the slave accepts it.
                lock_r     <= 1'b1;
                lock_win_r <= winner_s;
            end
        end
    end

endmodule
